// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: run/step/stop, hazard stalls, HALT drain.
// Optional executed-cycle counter enabled by PIPE_CTRL_CYCLE_COUNT_EN.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES   = 4,
    parameter int CYCLE_CNT_SIZE = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_run_cmd,
    input  logic                      i_step_cmd,
    input  logic                      i_stop_cmd,
    input  logic                      i_halt_detected,
    input  logic                      i_load_use_hazard,
    input  logic                      i_branch_taken,
    output logic                      o_pc_enable,
    output logic                      o_if_id_enable,
    output logic                      o_if_id_flush,
    output logic                      o_id_ex_enable,
    output logic                      o_id_ex_flush,
    output logic                      o_ex_mem_enable,
    output logic                      o_mem_wb_enable,
    output logic [2:0]                o_state,
    output logic                      o_end_program,
    output logic [CYCLE_CNT_SIZE-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] drain_cnt;
    logic [3:0] drain_nxt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        drain_nxt       = drain_cnt;
        o_pc_enable     = 1'b0;
        o_if_id_enable  = 1'b0;
        o_if_id_flush   = 1'b0;
        o_id_ex_enable  = 1'b0;
        o_id_ex_flush   = 1'b0;
        o_ex_mem_enable = 1'b0;
        o_mem_wb_enable = 1'b0;
        o_end_program   = 1'b0;
        case (state)
            IDLE: begin
                if (i_run_cmd) begin
                    state_nxt = RUN;
                end else if (i_step_cmd) begin
                    state_nxt = STEP;
                end
            end
            RUN, STEP: begin
                o_id_ex_enable  = 1'b1;
                o_ex_mem_enable = 1'b1;
                o_mem_wb_enable = 1'b1;
                if (i_halt_detected) begin
                    // the halt-detect cycle is itself the first drain cycle
                    o_id_ex_flush = 1'b1;
                    drain_nxt     = DRAIN_LOAD;
                    state_nxt     = (DRAIN_CYCLES == 1) ? DONE : DRAIN;
                end else begin
                    if (i_load_use_hazard) begin
                        o_id_ex_flush = 1'b1;
                    end else begin
                        o_pc_enable    = 1'b1;
                        o_if_id_enable = 1'b1;
                        o_if_id_flush  = i_branch_taken;
                    end
                    if (state == STEP || i_stop_cmd) begin
                        state_nxt = IDLE;
                    end
                end
            end
            DRAIN: begin
                o_id_ex_enable  = 1'b1;
                o_id_ex_flush   = 1'b1;
                o_ex_mem_enable = 1'b1;
                o_mem_wb_enable = 1'b1;
                if (drain_cnt != 4'd0) begin
                    drain_nxt = drain_cnt - 4'd1;
                end
                if (drain_cnt <= 4'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_end_program = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_state = state;

`ifdef PIPE_CTRL_CYCLE_COUNT_EN
    logic                      advance;
    logic [CYCLE_CNT_SIZE-1:0] cycle_cnt;

    assign advance = (state == RUN) || (state == STEP) || (state == DRAIN);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cycle_cnt <= '0;
        end else if (advance && !(&cycle_cnt)) begin
            cycle_cnt <= cycle_cnt + CYCLE_CNT_SIZE'(1);
        end
    end

    assign o_cycle_count = cycle_cnt;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: per-cycle model compare plus directed literals.
module tb_pipeline_ctrl;

    localparam int DC = 4;
    localparam int CW = 32;
`ifdef PIPE_CTRL_CYCLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_STEP  = 2;
    localparam int M_DRAIN = 3;
    localparam int M_DONE  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          step = 1'b0;
    logic          stop = 1'b0;
    logic          halt = 1'b0;
    logic          luh = 1'b0;
    logic          br = 1'b0;
    logic          pc_en;
    logic          if_id_en;
    logic          if_id_fl;
    logic          id_ex_en;
    logic          id_ex_fl;
    logic          ex_mem_en;
    logic          mem_wb_en;
    logic [2:0]    state;
    logic          end_prog;
    logic [CW-1:0] cyc;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .DRAIN_CYCLES  (DC),
        .CYCLE_CNT_SIZE(CW)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_run_cmd        (run),
        .i_step_cmd       (step),
        .i_stop_cmd       (stop),
        .i_halt_detected  (halt),
        .i_load_use_hazard(luh),
        .i_branch_taken   (br),
        .o_pc_enable      (pc_en),
        .o_if_id_enable   (if_id_en),
        .o_if_id_flush    (if_id_fl),
        .o_id_ex_enable   (id_ex_en),
        .o_id_ex_flush    (id_ex_fl),
        .o_ex_mem_enable  (ex_mem_en),
        .o_mem_wb_enable  (mem_wb_en),
        .o_state          (state),
        .o_end_program    (end_prog),
        .o_cycle_count    (cyc)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: mode, remaining drain cycles after the halt cycle, advance count
    int            mode = M_IDLE;
    int            left = 0;
    logic [CW-1:0] mcount = '0;
    bit            armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mode   = M_IDLE;
            left   = 0;
            mcount = '0;
        end else begin
            if (mode == M_RUN || mode == M_STEP || mode == M_DRAIN) begin
                if (mcount != '1) mcount = mcount + 1;
            end
            case (mode)
                M_IDLE: begin
                    if (run) mode = M_RUN;
                    else if (step) mode = M_STEP;
                end
                M_RUN, M_STEP: begin
                    if (halt) begin
                        left = DC - 1;
                        mode = (left == 0) ? M_DONE : M_DRAIN;
                    end else if (mode == M_STEP || stop) begin
                        mode = M_IDLE;
                    end
                end
                M_DRAIN: begin
                    left = left - 1;
                    if (left == 0) mode = M_DONE;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            bit adv;
            bit drn;
            bit go;
            logic [10:0] expv;
            adv = (mode == M_RUN || mode == M_STEP);
            drn = (mode == M_DRAIN);
            go  = adv && !halt && !luh;
            expv = {3'(mode), go, go, go && br, adv || drn,
                    drn || (adv && (halt || luh)), adv || drn, adv || drn,
                    mode == M_DONE};
            check("outputs",
                  {state, pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl,
                   ex_mem_en, mem_wb_en, end_prog}, expv);
            check("cycle_count", cyc, CNT_EN ? mcount : '0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pcs;
    int frozen;
    int drains;

    initial begin
        tick();
        armed = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        #3;
        check("idle_state", state, 0);
        check("idle_pc", pc_en, 0);
        check("idle_count", cyc, 0);
        check("idle_end", end_prog, 0);

        pcs = 0;
        repeat (3) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            repeat (4) begin
                #3;
                if (pc_en) pcs++;
                tick();
            end
        end
        #3;
        check("step_bursts", pcs, 3);
        check("step_count", cyc, CNT_EN ? 3 : 0);
        check("step_idle", state, 0);

        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        tick();
        luh = 1'b1;
        br = 1'b1;
        #3;
        check("luh_pc", pc_en, 0);
        check("luh_ifid_en", if_id_en, 0);
        check("luh_idex_flush", id_ex_fl, 1);
        check("luh_ifid_flush", if_id_fl, 0);
        tick();
        luh = 1'b0;
        #3;
        check("br_ifid_flush", if_id_fl, 1);
        check("br_pc", pc_en, 1);
        check("br_idex_flush", id_ex_fl, 0);
        tick();
        br = 1'b0;

        repeat (5) tick();
        halt = 1'b1;
        frozen = 0;
        drains = 0;
        #3;
        if (state inside {3'd1, 3'd2, 3'd3} && !pc_en) frozen++;
        tick();
        halt = 1'b0;
        repeat (7) begin
            #3;
            if (state inside {3'd1, 3'd2, 3'd3} && !pc_en) frozen++;
            if (state == 3'd3) drains++;
            tick();
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        #3;
        check("halt_frozen", frozen, 4);
        check("halt_drain_len", drains, 3);
        check("done_state", state, 4);
        check("done_end", end_prog, 1);

        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        check("rst_done_state", state, 0);
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        stop = 1'b1;
        halt = 1'b1;
        #3;
        check("stophalt_run", state, 1);
        tick();
        stop = 1'b0;
        halt = 1'b0;
        #3;
        check("stophalt_drain", state, 3);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #3;
        check("rst_drain_state", state, 0);
        check("rst_drain_count", cyc, 0);
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        #3;
        check("rerun_state", state, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        #3;
        check("stop_idle", state, 0);
        check("stop_count", cyc, CNT_EN ? 1 : 0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
